mc_axil_master: RTL and testbench
=================================

# mc_axil_master

Bridge between the MC request/acknowledge master interface and an AXI4-Lite master port. Sits directly downstream of the MC master controller: it accepts single-word write and read requests, issues the corresponding AXI4-Lite transactions, and returns acknowledge, response, read data and error flags. Write and read paths are fully independent and may be in flight simultaneously.
## Interface
- ADDR_WIDTH, 32, MC and AXI address width
- DATA_WIDTH, 32, data width (32 or 64); STRB_WIDTH = DATA_WIDTH/8 derived
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- MC_WREQ  in  1  write request; held high until after MC_BACK
- MC_WADDR  in  ADDR_WIDTH  write address, stable while MC_WREQ high
- MC_WDATA  in  DATA_WIDTH  write data, stable while MC_WREQ high
- MC_WACK  out  1  one-cycle pulse: address and data accepted
- MC_BACK  out  1  one-cycle pulse: write response received
- MC_WERROR  out  1  write error, valid with MC_BACK, held until next MC_BACK
- MC_RREQ  in  1  read request; held high until after MC_RACK
- MC_RADDR  in  ADDR_WIDTH  read address, stable while MC_RREQ high
- MC_RACK  out  1  one-cycle pulse: read data valid
- MC_RDATA  out  DATA_WIDTH  read data, valid with MC_RACK, held until next MC_RACK
- MC_RERROR  out  1  read error, valid with MC_RACK, held until next MC_RACK
- M_AXI_AWVALID out 1 / M_AXI_AWREADY in 1 / M_AXI_AWADDR out ADDR_WIDTH  write-address channel
- M_AXI_WVALID out 1 / M_AXI_WREADY in 1 / M_AXI_WDATA out DATA_WIDTH / M_AXI_WSTRB out STRB_WIDTH  write-data channel
- M_AXI_BVALID in 1 / M_AXI_BREADY out 1 / M_AXI_BRESP in 2  write-response channel
- M_AXI_ARVALID out 1 / M_AXI_ARREADY in 1 / M_AXI_ARADDR out ADDR_WIDTH  read-address channel
- M_AXI_RVALID in 1 / M_AXI_RREADY out 1 / M_AXI_RDATA in DATA_WIDTH / M_AXI_RRESP in 2  read-data channel
## Operation
- Write FSM: W_IDLE -> W_ADDR -> W_RESP -> W_REL -> W_IDLE; misaligned path W_IDLE -> W_ERR -> W_REL.
- W_IDLE: on MC_WREQ=1, latch address/data. If address not aligned to STRB_WIDTH bytes -> W_ERR; else assert AWVALID and WVALID -> W_ADDR.
- W_ADDR: AW and W tracked by separate done flags; each VALID drops on its own handshake, never earlier. When both done -> W_RESP, pulse MC_WACK.
- W_RESP: BREADY=1. On BVALID: pulse MC_BACK, MC_WERROR = (BRESP != OKAY) -> W_REL.
- W_ERR: pulse MC_WACK; next cycle pulse MC_BACK with MC_WERROR=1; no AXI traffic -> W_REL.
- W_REL: wait for MC_WREQ=0 -> W_IDLE (prevents re-launch on the still-high request).
- Read FSM: R_IDLE -> R_ADDR (ARVALID) -> R_DATA (RREADY) -> R_REL -> R_IDLE; misaligned -> R_ERR -> R_REL.
- R_DATA on RVALID: capture RDATA, MC_RERROR = (RRESP != OKAY), pulse MC_RACK. R_ERR: MC_RACK with MC_RERROR=1, MC_RDATA=0.
- WSTRB all ones. EXOKAY counts as error.
## Timing
- All outputs registered. Reset values: every VALID/READY, MC_WACK, MC_BACK, MC_RACK, error flags = 0; addresses, data, MC_RDATA = 0; both FSMs idle.
- MC_WREQ sampled at edge n -> AWVALID/WVALID high after n. Last of AW/W handshakes at edge h -> MC_WACK high for cycle h..h+1.
- BREADY from h; BVALID accepted at edge m (m >= h+1) -> MC_BACK high cycle m..m+1; always >= 1 cycle after MC_WACK.
- ARVALID after request edge; R handshake at edge r -> MC_RACK and MC_RDATA valid cycle r..r+1.
- Zero-wait slave: write MC_WACK 2 cycles and MC_BACK 3 cycles after request edge; read MC_RACK 3 cycles after.
- Simultaneous write and read requests: both launch the same cycle, no arbitration.
- Reset mid-transaction: all VALIDs drop asynchronously; FSMs return idle; no pulse emitted.
## Structure
- Package mc_axil_pkg: AXI response codes (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11), write/read state enums.
- Sub-module mc_axil_rd_ch holds the read FSM; write FSM inline in top.
## Test plan
- Write 0x04 <- 0x1111_1111, slave ready immediately, BRESP=OKAY -> AW/W one beat each, WACK then BACK, WERROR=0, single transaction only.
- Write 0x08, AWREADY 3 cycles before WREADY, BVALID 4 cycles late -> AWVALID drops first, WACK after WREADY, BACK after BVALID.
- Read 0x0c, slave returns 0x3333_3333 with SLVERR -> RACK pulse, MC_RDATA=0x3333_3333, MC_RERROR=1, held until next read.
- Write 0x06 (misaligned) -> no AWVALID/WVALID, WACK then BACK next cycle, WERROR=1.
- Concurrent write 0x10 and read 0x10 same cycle -> both channels active together, each MC handshake completes independently.
- rst_n low while AWVALID high -> all outputs 0 immediately; next request after reset completes normally.

Source files
------------

// File: rtl/mc_axil_pkg.sv
// Shared types for the MC-to-AXI4-Lite master bridge: response codes and
// the write/read channel state encodings.
package mc_axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_ADDR,
    W_RESP,
    W_ERR,
    W_REL
  } w_state_e;

  typedef enum logic [2:0] {
    R_IDLE,
    R_ADDR,
    R_DATA,
    R_ERR,
    R_REL
  } r_state_e;

  // EXOKAY is meaningless for non-exclusive AXI4-Lite accesses, so it is an error too.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/mc_axil_master_if.sv
// MC request/acknowledge port plus AXI4-Lite master port of the bridge.
// The master modport is the bridge's view; slave is the surrounding system.
interface mc_axil_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  MC_WREQ;
  logic [ADDR_WIDTH-1:0] MC_WADDR;
  logic [DATA_WIDTH-1:0] MC_WDATA;
  logic                  MC_WACK;
  logic                  MC_BACK;
  logic                  MC_WERROR;
  logic                  MC_RREQ;
  logic [ADDR_WIDTH-1:0] MC_RADDR;
  logic                  MC_RACK;
  logic [DATA_WIDTH-1:0] MC_RDATA;
  logic                  MC_RERROR;

  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [STRB_WIDTH-1:0] M_AXI_WSTRB;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;
  logic [1:0]            M_AXI_BRESP;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;

  modport master (
    input  MC_WREQ, MC_WADDR, MC_WDATA, MC_RREQ, MC_RADDR,
    output MC_WACK, MC_BACK, MC_WERROR, MC_RACK, MC_RDATA, MC_RERROR,
    output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    output M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    input  M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );

  modport slave (
    output MC_WREQ, MC_WADDR, MC_WDATA, MC_RREQ, MC_RADDR,
    input  MC_WACK, MC_BACK, MC_WERROR, MC_RACK, MC_RDATA, MC_RERROR,
    input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    input  M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    output M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );

endinterface

// File: rtl/mc_axil_rd_ch.sv
// Read channel of the MC-to-AXI4-Lite bridge: one AR beat, one R beat,
// then wait for the MC request to drop before accepting another.
module mc_axil_rd_ch
  import mc_axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rreq,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rack,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rerror,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp
);
  localparam int LSB_BITS = $clog2(DATA_WIDTH / 8);

  r_state_e              r_state_q, r_state_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rack_q, rack_d;
  logic                  rerror_q, rerror_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    r_state_d = r_state_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rack_d    = 1'b0;
    rerror_d  = rerror_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (rreq) begin
          araddr_d = raddr;
          if (raddr[LSB_BITS-1:0] != '0) begin
            r_state_d = R_ERR;
          end else begin
            arvalid_d = 1'b1;
            r_state_d = R_ADDR;
          end
        end
      end
      R_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid) begin
          rready_d  = 1'b0;
          rack_d    = 1'b1;
          rdata_d   = rdata_i;
          rerror_d  = resp_is_err(rresp);
          r_state_d = R_REL;
        end
      end
      R_ERR: begin
        rack_d    = 1'b1;
        rdata_d   = '0;
        rerror_d  = 1'b1;
        r_state_d = R_REL;
      end
      R_REL: begin
        if (!rreq) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rack_q    <= 1'b0;
      rerror_q  <= 1'b0;
      araddr_q  <= '0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rack_q    <= rack_d;
      rerror_q  <= rerror_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
    end
  end

  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;
  assign rready  = rready_q;
  assign rack    = rack_q;
  assign rdata_o = rdata_q;
  assign rerror  = rerror_q;

endmodule

// File: rtl/mc_axil_master.sv
// MC request/acknowledge to AXI4-Lite master bridge. The write FSM lives here;
// the independent read FSM is in mc_axil_rd_ch.
module mc_axil_master
  import mc_axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mc_axil_master_if.master   bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB_BITS   = $clog2(STRB_WIDTH);

  w_state_e              w_state_q, w_state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  bready_q, bready_d;
  logic                  wack_q, wack_d;
  logic                  back_q, back_d;
  logic                  werror_q, werror_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  aw_hs, w_hs;

  assign aw_hs = awvalid_q & bus.M_AXI_AWREADY;
  assign w_hs  = wvalid_q & bus.M_AXI_WREADY;

  // NOTE: every _d starts from its _q (pulses from 0) so no branch can infer a latch.
  always_comb begin
    w_state_d = w_state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bready_d  = bready_q;
    wack_d    = 1'b0;
    back_d    = 1'b0;
    werror_d  = werror_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    case (w_state_q)
      W_IDLE: begin
        if (bus.MC_WREQ) begin
          awaddr_d = bus.MC_WADDR;
          wdata_d  = bus.MC_WDATA;
          if (bus.MC_WADDR[LSB_BITS-1:0] != '0) begin
            wack_d    = 1'b1;
            w_state_d = W_ERR;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            w_state_d = W_ADDR;
          end
        end
      end
      W_ADDR: begin
        // AW and W may complete in either order; each VALID falls only on its own handshake.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          wack_d    = 1'b1;
          bready_d  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.M_AXI_BVALID) begin
          bready_d  = 1'b0;
          back_d    = 1'b1;
          werror_d  = resp_is_err(bus.M_AXI_BRESP);
          w_state_d = W_REL;
        end
      end
      W_ERR: begin
        back_d    = 1'b1;
        werror_d  = 1'b1;
        w_state_d = W_REL;
      end
      W_REL: begin
        // The request is still high after BACK; wait for it to drop so it is not relaunched.
        if (!bus.MC_WREQ) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      wack_q    <= 1'b0;
      back_q    <= 1'b0;
      werror_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bready_q  <= bready_d;
      wack_q    <= wack_d;
      back_q    <= back_d;
      werror_q  <= werror_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_AWADDR  = awaddr_q;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = '1;
  assign bus.M_AXI_BREADY  = bready_q;
  assign bus.MC_WACK       = wack_q;
  assign bus.MC_BACK       = back_q;
  assign bus.MC_WERROR     = werror_q;

  logic                  rd_rack, rd_rerror, rd_arvalid, rd_rready;
  logic [DATA_WIDTH-1:0] rd_rdata;
  logic [ADDR_WIDTH-1:0] rd_araddr;

  mc_axil_rd_ch #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_ch (
    .clk     (clk),
    .rst_n   (rst_n),
    .rreq    (bus.MC_RREQ),
    .raddr   (bus.MC_RADDR),
    .rack    (rd_rack),
    .rdata_o (rd_rdata),
    .rerror  (rd_rerror),
    .arvalid (rd_arvalid),
    .arready (bus.M_AXI_ARREADY),
    .araddr  (rd_araddr),
    .rvalid  (bus.M_AXI_RVALID),
    .rready  (rd_rready),
    .rdata_i (bus.M_AXI_RDATA),
    .rresp   (bus.M_AXI_RRESP)
  );

  assign bus.MC_RACK       = rd_rack;
  assign bus.MC_RDATA      = rd_rdata;
  assign bus.MC_RERROR     = rd_rerror;
  assign bus.M_AXI_ARVALID = rd_arvalid;
  assign bus.M_AXI_ARADDR  = rd_araddr;
  assign bus.M_AXI_RREADY  = rd_rready;

endmodule

// File: tb/tb_mc_axil_master.sv
// Bench for mc_axil_master: directed MC requests against a delay-programmable
// AXI4-Lite slave, with a scoreboard of expected MC responses and AXI beats.
module tb_mc_axil_master;
  import mc_axil_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mc_axil_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mc_axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int            req_cyc;
    int            ack_lat;
    int            done_lat;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          wq[$];
  exp_t          rq[$];
  logic [AW-1:0] aw_q[$];
  logic [DW-1:0] wd_q[$];
  logic [AW-1:0] ar_q[$];

  // Slave behaviour knobs: wait cycles before READY/VALID, and response fields.
  int            aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]    b_resp_cfg = RESP_OKAY;
  logic [1:0]    r_resp_cfg = RESP_OKAY;
  logic [DW-1:0] r_data_cfg = '0;

  int aw_hs_cnt = 0, w_hs_cnt = 0, awvalid_cycles = 0, wvalid_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // AXI4-Lite slave: decisions at the falling edge, so the rising edge sees stable inputs.
  initial begin
    bit aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    bit aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    bit prev_aw = 0, prev_w = 0, prev_ar = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [AW-1:0] aw_cap = '0, ar_cap = '0;
    logic [DW-1:0] w_cap = '0;
    logic [DW/8-1:0] s_cap = '0;
    bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_BVALID = 1'b0;
    bus.M_AXI_BRESP = 2'b00;  bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RVALID = 1'b0;
    bus.M_AXI_RDATA = '0;     bus.M_AXI_RRESP = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        prev_aw = 0; prev_w = 0; prev_ar = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_BVALID = 1'b0;
        bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RVALID = 1'b0;
      end else begin
        if (prev_aw && !bus.M_AXI_AWVALID) check("awvalid_drop_needs_hs", aw_hs, 1);
        if (prev_w && !bus.M_AXI_WVALID)   check("wvalid_drop_needs_hs", w_hs, 1);
        if (prev_ar && !bus.M_AXI_ARVALID) check("arvalid_drop_needs_hs", ar_hs, 1);
        if (aw_hs) begin
          aw_got = 1; aw_hs_cnt++;
          if (aw_q.size() == 0) fail_evt("aw_beat", "address beat with nothing expected");
          else check("awaddr", aw_cap, aw_q.pop_front());
        end
        if (w_hs) begin
          w_got = 1; w_hs_cnt++;
          check("wstrb", s_cap, 4'hf);
          if (wd_q.size() == 0) fail_evt("w_beat", "data beat with nothing expected");
          else check("wdata", w_cap, wd_q.pop_front());
        end
        if (ar_hs) begin
          r_pend = 1; r_wait = 0;
          if (ar_q.size() == 0) fail_evt("ar_beat", "read address with nothing expected");
          else check("araddr", ar_cap, ar_q.pop_front());
        end
        if (b_hs) begin bus.M_AXI_BVALID = 1'b0; b_pend = 0; end
        if (r_hs) begin bus.M_AXI_RVALID = 1'b0; r_pend = 0; end
        if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0; end
        if (b_pend && !bus.M_AXI_BVALID) begin
          if (b_wait >= b_delay) begin bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = b_resp_cfg; end
          else b_wait++;
        end
        if (r_pend && !bus.M_AXI_RVALID) begin
          if (r_wait >= r_delay) begin
            bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RDATA = r_data_cfg; bus.M_AXI_RRESP = r_resp_cfg;
          end else r_wait++;
        end
        if (bus.M_AXI_AWVALID) begin
          awvalid_cycles++;
          if (aw_wait >= aw_delay) bus.M_AXI_AWREADY = 1'b1;
          else begin bus.M_AXI_AWREADY = 1'b0; aw_wait++; end
        end else begin bus.M_AXI_AWREADY = 1'b0; aw_wait = 0; end
        if (bus.M_AXI_WVALID) begin
          wvalid_cycles++;
          if (w_wait >= w_delay) bus.M_AXI_WREADY = 1'b1;
          else begin bus.M_AXI_WREADY = 1'b0; w_wait++; end
        end else begin bus.M_AXI_WREADY = 1'b0; w_wait = 0; end
        if (bus.M_AXI_ARVALID) begin
          if (ar_wait >= ar_delay) bus.M_AXI_ARREADY = 1'b1;
          else begin bus.M_AXI_ARREADY = 1'b0; ar_wait++; end
        end else begin bus.M_AXI_ARREADY = 1'b0; ar_wait = 0; end
        aw_hs = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY; aw_cap = bus.M_AXI_AWADDR;
        w_hs  = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
        w_cap = bus.M_AXI_WDATA; s_cap = bus.M_AXI_WSTRB;
        ar_hs = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY; ar_cap = bus.M_AXI_ARADDR;
        b_hs  = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
        r_hs  = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
        prev_aw = bus.M_AXI_AWVALID; prev_w = bus.M_AXI_WVALID; prev_ar = bus.M_AXI_ARVALID;
      end
    end
  end

  // MC-side monitor: pops the scoreboard whenever the bridge pulses an acknowledge.
  initial begin
    logic prev_wack = 0, prev_back = 0, prev_rack = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.MC_WACK) begin
          check("wack_one_cycle", prev_wack, 0);
          if (wq.size() == 0) fail_evt("wack", "acknowledge with no write outstanding");
          else check("wack_latency", cyc - wq[0].req_cyc, wq[0].ack_lat);
        end
        if (bus.MC_BACK) begin
          check("back_one_cycle", prev_back, 0);
          if (wq.size() == 0) fail_evt("back", "response with no write outstanding");
          else begin
            e = wq.pop_front();
            check("back_latency", cyc - e.req_cyc, e.done_lat);
            check("werror", bus.MC_WERROR, e.err);
          end
        end
        if (bus.MC_RACK) begin
          check("rack_one_cycle", prev_rack, 0);
          if (rq.size() == 0) fail_evt("rack", "read data with no read outstanding");
          else begin
            e = rq.pop_front();
            check("rack_latency", cyc - e.req_cyc, e.done_lat);
            check("rdata", bus.MC_RDATA, e.data);
            check("rerror", bus.MC_RERROR, e.err);
          end
        end
        prev_wack = bus.MC_WACK; prev_back = bus.MC_BACK; prev_rack = bus.MC_RACK;
      end else begin
        prev_wack = 0; prev_back = 0; prev_rack = 0;
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic err, input int ack_lat, input int back_lat);
    exp_t e;
    bit   got = 0;
    @(negedge clk);
    bus.MC_WREQ = 1'b1; bus.MC_WADDR = addr; bus.MC_WDATA = data;
    e.req_cyc = cyc; e.ack_lat = ack_lat; e.done_lat = back_lat; e.err = err; e.data = '0;
    wq.push_back(e);
    if (addr[1:0] == 2'b00) begin aw_q.push_back(addr); wd_q.push_back(data); end
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = bus.MC_BACK;
    end
    if (!got) fail_evt("write_timeout", "MC_BACK not seen within 64 cycles");
    bus.MC_WREQ = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic err, input int lat);
    exp_t e;
    bit   got = 0;
    @(negedge clk);
    bus.MC_RREQ = 1'b1; bus.MC_RADDR = addr;
    e.req_cyc = cyc; e.ack_lat = 0; e.done_lat = lat; e.err = err; e.data = data;
    rq.push_back(e);
    if (addr[1:0] == 2'b00) ar_q.push_back(addr);
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = bus.MC_RACK;
    end
    if (!got) fail_evt("read_timeout", "MC_RACK not seen within 64 cycles");
    bus.MC_RREQ = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                            bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.MC_WACK, bus.MC_BACK,
                            bus.MC_RACK, bus.MC_WERROR, bus.MC_RERROR}, 0);
    check({name, "_awaddr"}, bus.M_AXI_AWADDR, 0);
    check({name, "_wdata"},  bus.M_AXI_WDATA, 0);
    check({name, "_araddr"}, bus.M_AXI_ARADDR, 0);
    check({name, "_rdata"},  bus.MC_RDATA, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int aw_snap, w_snap;
    bus.MC_WREQ = 1'b0; bus.MC_WADDR = '0; bus.MC_WDATA = '0;
    bus.MC_RREQ = 1'b0; bus.MC_RADDR = '0;
    #12;
    check_all_zero("reset_state");
    @(negedge clk); #2 rst_n = 1'b1;

    // Zero-wait write: one beat per channel, ACK 2 and BACK 3 cycles after the request.
    do_write(32'h04, 32'h1111_1111, 1'b0, 2, 3);
    check("single_aw_beat", aw_hs_cnt, 1);
    check("single_w_beat", w_hs_cnt, 1);

    // AW accepted at once, W three cycles later, B four cycles after that.
    w_delay = 3; b_delay = 4;
    do_write(32'h08, 32'h2222_2222, 1'b0, 5, 10);
    w_delay = 0; b_delay = 0;

    // SLVERR read: data and error are returned and held afterwards.
    r_data_cfg = 32'h3333_3333; r_resp_cfg = RESP_SLVERR;
    do_read(32'h0c, 32'h3333_3333, 1'b1, 3);
    repeat (3) @(negedge clk);
    check("rdata_held", bus.MC_RDATA, 32'h3333_3333);
    check("rerror_held", bus.MC_RERROR, 1);

    // Misaligned write: no AXI traffic, ACK then BACK on the next cycle with error.
    aw_snap = awvalid_cycles; w_snap = wvalid_cycles;
    do_write(32'h06, 32'h5555_5555, 1'b1, 1, 2);
    check("misaligned_no_awvalid", awvalid_cycles, aw_snap);
    check("misaligned_no_wvalid", wvalid_cycles, w_snap);
    repeat (2) @(negedge clk);
    check("werror_held", bus.MC_WERROR, 1);

    // OKAY clears the error flag; EXOKAY sets it again.
    do_write(32'h18, 32'h1234_5678, 1'b0, 2, 3);
    b_resp_cfg = RESP_EXOKAY;
    do_write(32'h20, 32'h6666_6666, 1'b1, 2, 3);
    b_resp_cfg = RESP_OKAY;

    // Misaligned read: error response with zero data.
    do_read(32'h0e, 32'h0, 1'b1, 2);

    // Concurrent write and read to the same address.
    r_data_cfg = 32'h4444_4444; r_resp_cfg = RESP_OKAY;
    fork
      do_write(32'h10, 32'h7777_7777, 1'b0, 2, 3);
      do_read(32'h10, 32'h4444_4444, 1'b0, 3);
      begin
        repeat (2) @(negedge clk);
        check("concurrent_aw_ar", {bus.M_AXI_AWVALID, bus.M_AXI_ARVALID}, 2'b11);
      end
    join

    // Reset while AWVALID is high: everything clears at once, nothing is acknowledged.
    aw_delay = 6; w_delay = 6;
    @(negedge clk);
    bus.MC_WREQ = 1'b1; bus.MC_WADDR = 32'h14; bus.MC_WDATA = 32'hdead_beef;
    repeat (2) @(negedge clk);
    check("awvalid_before_reset", bus.M_AXI_AWVALID, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    bus.MC_WREQ = 1'b0;
    aw_delay = 0; w_delay = 0;
    @(negedge clk); #2 rst_n = 1'b1;

    do_write(32'h14, 32'h8888_8888, 1'b0, 2, 3);
    r_data_cfg = 32'h9999_9999;
    do_read(32'h14, 32'h9999_9999, 1'b0, 3);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", wq.size() + rq.size() + aw_q.size() + wd_q.size() + ar_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
